// File: rtl/pwm_ctrl_regs_if.sv
// Valid/ready register-bus bundle between a bus master and pwm_ctrl_regs.
// Signal names keep the slave-side direction suffixes used by the register block.
interface pwm_ctrl_regs_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [5:0]  req_addr_i;
   logic [31:0] req_wdata_i;
   logic [3:0]  req_wstrb_i;
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i, resp_ready_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
   );

   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i, resp_ready_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
   );
endinterface

// File: rtl/pwm_ctrl_regs.sv
// Shadow/active configuration registers for two PWM channels; shadow values are
// committed to the generator-facing active set only at each channel's period boundary.
module pwm_ctrl_regs #(
   parameter int unsigned CH_STRIDE = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   pwm_ctrl_regs_if.slave bus,
   output logic [1:0]  pwm0_mode_o,
   output logic [31:0] pwm0_period_o,
   output logic [31:0] pwm0_threshold1_o,
   output logic [31:0] pwm0_threshold2_o,
   output logic [11:0] pwm0_step_o,
   output logic [1:0]  pwm1_mode_o,
   output logic [31:0] pwm1_period_o,
   output logic [31:0] pwm1_threshold1_o,
   output logic [31:0] pwm1_threshold2_o,
   output logic [11:0] pwm1_step_o
);

   localparam int unsigned NCH     = 2;
   localparam int unsigned DW      = 32;
   localparam int unsigned MW      = 2;
   localparam int unsigned SW      = 12;
   localparam int unsigned OFF_ERR = 32'h18;

   logic [MW-1:0] sh_mode_q   [NCH];
   logic [MW-1:0] sh_mode_d   [NCH];
   logic [DW-1:0] sh_period_q [NCH];
   logic [DW-1:0] sh_period_d [NCH];
   logic [DW-1:0] sh_thr1_q   [NCH];
   logic [DW-1:0] sh_thr1_d   [NCH];
   logic [DW-1:0] sh_thr2_q   [NCH];
   logic [DW-1:0] sh_thr2_d   [NCH];
   logic [SW-1:0] sh_step_q   [NCH];
   logic [SW-1:0] sh_step_d   [NCH];

   logic [MW-1:0] act_mode_q   [NCH];
   logic [MW-1:0] act_mode_d   [NCH];
   logic [DW-1:0] act_period_q [NCH];
   logic [DW-1:0] act_period_d [NCH];
   logic [DW-1:0] act_thr1_q   [NCH];
   logic [DW-1:0] act_thr1_d   [NCH];
   logic [DW-1:0] act_thr2_q   [NCH];
   logic [DW-1:0] act_thr2_d   [NCH];
   logic [SW-1:0] act_step_q   [NCH];
   logic [SW-1:0] act_step_d   [NCH];

   logic [DW-1:0] bcnt_q [NCH];
   logic [DW-1:0] bcnt_d [NCH];
   logic [NCH-1:0] pending_q, pending_d;
   logic [NCH-1:0] boundary;

   logic          resp_valid_q, resp_valid_d;
   logic [DW-1:0] resp_rdata_q, resp_rdata_d;
   logic          resp_err_q, resp_err_d;

   logic          req_acc;
   logic [DW-1:0] addr_w;
   logic [DW-1:0] off_w;
   logic          ch_sel;
   logic          dec_err;
   logic [2:0]    reg_idx;
   logic [DW-1:0] rd_data_c;

   function automatic logic [31:0] wmerge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

   // Only one response may be outstanding; a consumed response frees the slot in the same cycle.
   assign bus.req_ready_o  = !resp_valid_q || bus.resp_ready_i;
   assign bus.resp_valid_o = resp_valid_q;
   assign bus.resp_rdata_o = resp_rdata_q;
   assign bus.resp_err_o   = resp_err_q;
   assign req_acc          = bus.req_valid_i && bus.req_ready_o;

   // Address decode: bank select, in-bank offset and error detection.
   always_comb begin
      addr_w = DW'(bus.req_addr_i);
      ch_sel = 1'b0;
      off_w  = addr_w;
      if (addr_w >= CH_STRIDE) begin
         ch_sel = 1'b1;
         off_w  = addr_w - CH_STRIDE;
      end
      dec_err = (bus.req_addr_i[1:0] != 2'b00) || (off_w >= OFF_ERR) ||
                (addr_w >= 2 * CH_STRIDE);
      reg_idx = off_w[4:2];
   end

   always_comb begin
      rd_data_c = '0;
      case (reg_idx)
         3'd0:    rd_data_c = DW'(sh_mode_q[ch_sel]);
         3'd1:    rd_data_c = sh_period_q[ch_sel];
         3'd2:    rd_data_c = sh_thr1_q[ch_sel];
         3'd3:    rd_data_c = sh_thr2_q[ch_sel];
         3'd4:    rd_data_c = DW'(sh_step_q[ch_sel]);
         3'd5:    rd_data_c = DW'(pending_q[ch_sel]);
         default: rd_data_c = '0;
      endcase
   end

   always_comb begin
      sh_mode_d    = sh_mode_q;
      sh_period_d  = sh_period_q;
      sh_thr1_d    = sh_thr1_q;
      sh_thr2_d    = sh_thr2_q;
      sh_step_d    = sh_step_q;
      act_mode_d   = act_mode_q;
      act_period_d = act_period_q;
      act_thr1_d   = act_thr1_q;
      act_thr2_d   = act_thr2_q;
      act_step_d   = act_step_q;
      bcnt_d       = bcnt_q;
      pending_d    = pending_q;
      boundary     = '0;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;

      // Boundary tracking and commit use pre-write shadow values.
      for (int c = 0; c < NCH; c++) begin
         boundary[c] = (act_mode_q[c] == '0) || (act_period_q[c] <= 32'd1) ||
                       (bcnt_q[c] >= act_period_q[c] - 32'd1);
         bcnt_d[c]   = boundary[c] ? '0 : bcnt_q[c] + 32'd1;
         if (pending_q[c] && boundary[c]) begin
            act_mode_d[c]   = sh_mode_q[c];
            act_period_d[c] = sh_period_q[c];
            act_thr1_d[c]   = sh_thr1_q[c];
            act_thr2_d[c]   = sh_thr2_q[c];
            act_step_d[c]   = sh_step_q[c];
            pending_d[c]    = 1'b0;
         end
      end

      // An APPLY in the commit cycle re-arms pending for the next boundary.
      if (req_acc) begin
         resp_valid_d = 1'b1;
         resp_rdata_d = '0;
         resp_err_d   = 1'b0;
         if (dec_err) begin
            resp_err_d = 1'b1;
         end else if (bus.req_we_i) begin
            case (reg_idx)
               3'd0: sh_mode_d[ch_sel] = MW'(wmerge(DW'(sh_mode_q[ch_sel]),
                                                    bus.req_wdata_i, bus.req_wstrb_i));
               3'd1: sh_period_d[ch_sel] = wmerge(sh_period_q[ch_sel],
                                                  bus.req_wdata_i, bus.req_wstrb_i);
               3'd2: sh_thr1_d[ch_sel] = wmerge(sh_thr1_q[ch_sel],
                                                bus.req_wdata_i, bus.req_wstrb_i);
               3'd3: sh_thr2_d[ch_sel] = wmerge(sh_thr2_q[ch_sel],
                                                bus.req_wdata_i, bus.req_wstrb_i);
               3'd4: sh_step_d[ch_sel] = SW'(wmerge(DW'(sh_step_q[ch_sel]),
                                                    bus.req_wdata_i, bus.req_wstrb_i));
               3'd5: if (bus.req_wstrb_i[0] && bus.req_wdata_i[0]) pending_d[ch_sel] = 1'b1;
               default: ;
            endcase
         end else begin
            resp_rdata_d = rd_data_c;
         end
      end else if (resp_valid_q && bus.resp_ready_i) begin
         resp_valid_d = 1'b0;
         resp_rdata_d = '0;
         resp_err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int c = 0; c < NCH; c++) begin
            sh_mode_q[c]    <= '0;
            sh_period_q[c]  <= '0;
            sh_thr1_q[c]    <= '0;
            sh_thr2_q[c]    <= '0;
            sh_step_q[c]    <= '0;
            act_mode_q[c]   <= '0;
            act_period_q[c] <= '0;
            act_thr1_q[c]   <= '0;
            act_thr2_q[c]   <= '0;
            act_step_q[c]   <= '0;
            bcnt_q[c]       <= '0;
         end
         pending_q    <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         sh_mode_q    <= sh_mode_d;
         sh_period_q  <= sh_period_d;
         sh_thr1_q    <= sh_thr1_d;
         sh_thr2_q    <= sh_thr2_d;
         sh_step_q    <= sh_step_d;
         act_mode_q   <= act_mode_d;
         act_period_q <= act_period_d;
         act_thr1_q   <= act_thr1_d;
         act_thr2_q   <= act_thr2_d;
         act_step_q   <= act_step_d;
         bcnt_q       <= bcnt_d;
         pending_q    <= pending_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign pwm0_mode_o       = act_mode_q[0];
   assign pwm0_period_o     = act_period_q[0];
   assign pwm0_threshold1_o = act_thr1_q[0];
   assign pwm0_threshold2_o = act_thr2_q[0];
   assign pwm0_step_o       = act_step_q[0];
   assign pwm1_mode_o       = act_mode_q[1];
   assign pwm1_period_o     = act_period_q[1];
   assign pwm1_threshold1_o = act_thr1_q[1];
   assign pwm1_threshold2_o = act_thr2_q[1];
   assign pwm1_step_o       = act_step_q[1];

endmodule

// File: tb/tb_pwm_ctrl_regs.sv
// Scoreboard bench for pwm_ctrl_regs: the driver queues expected responses on accept,
// a monitor pops and compares them as responses are consumed.
module tb_pwm_ctrl_regs;

   logic clk = 1'b0;
   logic rst_i;
   always #5 clk = ~clk;

   pwm_ctrl_regs_if bus ();

   logic [1:0]  pwm0_mode, pwm1_mode;
   logic [31:0] pwm0_period, pwm0_thr1, pwm0_thr2, pwm1_period, pwm1_thr1, pwm1_thr2;
   logic [11:0] pwm0_step, pwm1_step;

   pwm_ctrl_regs #(.CH_STRIDE(32)) dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .bus               (bus),
      .pwm0_mode_o       (pwm0_mode),
      .pwm0_period_o     (pwm0_period),
      .pwm0_threshold1_o (pwm0_thr1),
      .pwm0_threshold2_o (pwm0_thr2),
      .pwm0_step_o       (pwm0_step),
      .pwm1_mode_o       (pwm1_mode),
      .pwm1_period_o     (pwm1_period),
      .pwm1_threshold1_o (pwm1_thr1),
      .pwm1_threshold2_o (pwm1_thr2),
      .pwm1_step_o       (pwm1_step)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [32:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Response monitor: compare each consumed response against the oldest expectation.
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (bus.resp_valid_o && bus.resp_ready_i) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_resp: got rdata 0x%08h err %0b with nothing queued",
                        bus.resp_rdata_o, bus.resp_err_o);
            end else begin
               e = exp_q.pop_front();
               check("resp_rdata", bus.resp_rdata_o, e[31:0]);
               check("resp_err", 32'(bus.resp_err_o), 32'(e[32]));
            end
         end
      end
   end

   // Issue one request; returns just after the accepting edge.
   task automatic bus_req(input logic we, input logic [5:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                          input logic exp_err);
      int waitc;
      waitc = 0;
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = we;
      bus.req_addr_i  = addr;
      bus.req_wdata_i = wdata;
      bus.req_wstrb_i = wstrb;
      forever begin
         @(negedge clk);
         if (bus.req_ready_o) break;
         waitc++;
         if (waitc > 50) break;
      end
      if (!bus.req_ready_o) begin
         n_tests++;
         n_fail++;
         $display("FAIL req_timeout: addr 0x%02h never accepted, got ready 0 expected 1", addr);
         bus.req_valid_i = 1'b0;
         return;
      end
      exp_q.push_back({exp_err, exp_rdata});
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
   endtask

   task automatic wr(input logic [5:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     input logic exp_err);
      bus_req(1'b1, addr, wdata, wstrb, 32'h0, exp_err);
   endtask

   task automatic rd(input logic [5:0] addr, input logic [31:0] exp_rdata, input logic exp_err);
      bus_req(1'b0, addr, 32'h0, 4'h0, exp_rdata, exp_err);
   endtask

   initial begin
      int waitc;
      rst_i            = 1'b0;
      bus.req_valid_i  = 1'b0;
      bus.req_we_i     = 1'b0;
      bus.req_addr_i   = '0;
      bus.req_wdata_i  = '0;
      bus.req_wstrb_i  = '0;
      bus.resp_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b1;

      // Reset state
      check("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
      check("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
      check("rst_pwm0_mode", 32'(pwm0_mode), 32'd0);
      check("rst_pwm0_period", pwm0_period, 32'd0);
      check("rst_pwm1_period", pwm1_period, 32'd0);
      check("rst_pwm1_step", 32'(pwm1_step), 32'd0);
      rd(6'h04, 32'h0, 1'b0);

      // Channel 0 apply while mode 0 is active: outputs move two edges after accept
      wr(6'h04, 32'd10, 4'hF, 1'b0);
      wr(6'h08, 32'd4, 4'hF, 1'b0);
      wr(6'h00, 32'd1, 4'hF, 1'b0);
      rd(6'h14, 32'd0, 1'b0);
      wr(6'h14, 32'd1, 4'hF, 1'b0);
      @(negedge clk);
      check("apply0_early_period", pwm0_period, 32'd0);
      check("apply0_early_mode", 32'(pwm0_mode), 32'd0);
      @(negedge clk);
      check("apply0_period", pwm0_period, 32'd10);
      check("apply0_thr1", pwm0_thr1, 32'd4);
      check("apply0_mode", 32'(pwm0_mode), 32'd1);
      check("apply0_ch1_period", pwm1_period, 32'd0);
      check("apply0_ch1_mode", 32'(pwm1_mode), 32'd0);

      // Mode 1, period 10: commit at the edge 10 after the previous commit
      @(posedge clk);
      #1;
      wr(6'h08, 32'd7, 4'hF, 1'b0);
      wr(6'h14, 32'd1, 4'hF, 1'b0);
      rd(6'h14, 32'd1, 1'b0);
      check("period_thr1_hold", pwm0_thr1, 32'd4);
      for (int j = 5; j <= 12; j++) begin
         @(posedge clk);
         #1;
         check($sformatf("period_thr1_edge%0d", j), pwm0_thr1, (j >= 10) ? 32'd7 : 32'd4);
      end
      rd(6'h14, 32'd0, 1'b0);
      check("period_keep", pwm0_period, 32'd10);

      // Byte strobes on channel 1 THR1
      wr(6'h28, 32'hAABBCCDD, 4'b0101, 1'b0);
      rd(6'h28, 32'h00BB00DD, 1'b0);

      // Errors and unimplemented bits
      rd(6'h02, 32'h0, 1'b1);
      wr(6'h18, 32'h12345678, 4'hF, 1'b1);
      rd(6'h1C, 32'h0, 1'b1);
      wr(6'h3A, 32'h1, 4'hF, 1'b1);
      rd(6'h04, 32'd10, 1'b0);
      wr(6'h00, 32'hFFFFFFFF, 4'hF, 1'b0);
      rd(6'h00, 32'd3, 1'b0);
      wr(6'h30, 32'hFFFFFFFF, 4'hF, 1'b0);
      rd(6'h30, 32'h00000FFF, 1'b0);

      // APPLY without bit0 or without byte-0 strobe does nothing
      wr(6'h34, 32'h0, 4'hF, 1'b0);
      rd(6'h34, 32'd0, 1'b0);
      wr(6'h34, 32'h1, 4'b1110, 1'b0);
      rd(6'h34, 32'd0, 1'b0);
      check("noapply_ch1_thr1", pwm1_thr1, 32'd0);

      // Channel 1 apply with mode 0 active
      wr(6'h34, 32'h1, 4'h1, 1'b0);
      @(negedge clk);
      check("apply1_early_thr1", pwm1_thr1, 32'd0);
      @(negedge clk);
      check("apply1_thr1", pwm1_thr1, 32'h00BB00DD);
      check("apply1_step", 32'(pwm1_step), 32'h0FFF);
      check("apply1_ch0_thr1", pwm0_thr1, 32'd7);

      // Backpressure: response held, request stalled, then both complete on one edge
      @(posedge clk);
      #1;
      bus.resp_ready_i = 1'b0;
      rd(6'h08, 32'd7, 1'b0);
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = 1'b0;
      bus.req_addr_i  = 6'h04;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_req_ready", 32'(bus.req_ready_o), 32'd0);
         check("bp_resp_valid", 32'(bus.resp_valid_o), 32'd1);
         check("bp_resp_rdata", bus.resp_rdata_o, 32'd7);
      end
      @(posedge clk);
      #1;
      bus.resp_ready_i = 1'b1;
      @(negedge clk);
      check("bp_release_ready", 32'(bus.req_ready_o), 32'd1);
      exp_q.push_back({1'b0, 32'd10});
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
      @(negedge clk);
      check("bp_second_resp_valid", 32'(bus.resp_valid_o), 32'd1);

      // Reset with a response outstanding and pending set
      @(posedge clk);
      #1;
      bus.resp_ready_i = 1'b0;
      wr(6'h14, 32'h1, 4'hF, 1'b0);
      rst_i = 1'b0;
      @(posedge clk);
      #1;
      rst_i = 1'b1;
      exp_q.delete();
      bus.resp_ready_i = 1'b1;
      check("mrst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
      check("mrst_pwm0_mode", 32'(pwm0_mode), 32'd0);
      check("mrst_pwm0_thr1", pwm0_thr1, 32'd0);
      check("mrst_pwm1_thr1", pwm1_thr1, 32'd0);
      rd(6'h14, 32'd0, 1'b0);
      rd(6'h08, 32'd0, 1'b0);

      waitc = 0;
      while (exp_q.size() != 0 && waitc < 100) begin
         @(posedge clk);
         waitc++;
      end
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d responses outstanding, expected 0", exp_q.size());
      end
      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_ctrl_regs.md
# pwm_ctrl_regs

Memory-mapped control block directly upstream of the PWM generators: a simple valid/ready bus slave holding configuration for two PWM channels (mode, period, two thresholds, step). Software writes land in shadow registers. A per-channel apply request copies shadow to active only at that channel's period boundary. The active registers drive the generators' `*_mode_i/period_i/threshold1_i/threshold2_i/step_i` inputs, so a configuration never changes mid-period.

## Interface
- `CH_STRIDE`, default 32: byte offset between channel register banks (channel 0 at 0x00, channel 1 at 0x20).
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: synchronous reset, active-low (reset when `rst_i==0` at a rising edge).
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: request accepted when `req_valid_i && req_ready_o`.
- `req_we_i` in 1: 1 = write, 0 = read.
- `req_addr_i` in 6: byte address.
- `req_wdata_i` in 32: write data.
- `req_wstrb_i` in 4: byte enables for writes.
- `resp_valid_o` out 1: response present.
- `resp_ready_i` in 1: response consumed when `resp_valid_o && resp_ready_i`.
- `resp_rdata_o` out 32: read data; 0 for writes and errors.
- `resp_err_o` out 1: decode or alignment error.
- `pwm0_mode_o` / `pwm1_mode_o` out 2: active mode, per channel.
- `pwm0_period_o` / `pwm1_period_o` out 32: active period, per channel.
- `pwm0_threshold1_o` / `pwm1_threshold1_o` out 32: active threshold 1, per channel.
- `pwm0_threshold2_o` / `pwm1_threshold2_o` out 32: active threshold 2, per channel.
- `pwm0_step_o` / `pwm1_step_o` out 12: active step, per channel.

## Operation
- Per-channel offsets:
  - 0x00 MODE[1:0]
  - 0x04 PERIOD
  - 0x08 THR1
  - 0x0C THR2
  - 0x10 STEP[11:0]
  - 0x14 APPLY: write bit0=1 sets `pending`; read returns {31'b0, pending}.
  - Unused upper bits of MODE/STEP read as 0 and ignore writes.
- Writes to 0x00–0x10 update the shadow copy, byte-wise per `req_wstrb_i`. Reads of 0x00–0x10 return shadow, not active.
- APPLY write with bit0=0, or with `req_wstrb_i[0]==0`, has no effect. Response is still OK.
- Error (`resp_err_o=1`, no state change, rdata 0) for:
  - `req_addr_i[1:0]!=0`;
  - offsets 0x18–0x1C within a bank.
- Boundary tracker, per channel:
  - `bcnt` (32 bit) increments each cycle while active mode != 0.
  - boundary = (active mode == 0) OR (`bcnt >= active_period - 1`), with `active_period` 0 or 1 giving a boundary every cycle.
  - `bcnt` clears to 0 at every boundary.
- Commit, per channel: in a cycle where `pending && boundary`, all five active fields load from shadow, `pending` clears, and `bcnt` clears.
- Simultaneous events in the commit cycle:
  - A shadow write in that cycle is not included; the commit takes pre-write shadow values.
  - An APPLY write in that cycle leaves `pending=1` for the next boundary.
- Channels are independent. One bus access targets one channel only.

## Timing
- Reset values:
  - all shadow, active and `bcnt` = 0; `pending` = 0;
  - `resp_valid_o` = 0, `resp_rdata_o` = 0, `resp_err_o` = 0;
  - `req_ready_o` = 1 in the first cycle after reset.
- `req_ready_o = !resp_valid_o || resp_ready_i`. At most one outstanding response.
- Request accepted at edge N:
  - `resp_valid_o`, `resp_rdata_o` and `resp_err_o` are valid from N+1.
  - They hold stable until consumed.
  - Back-to-back throughput is one access per cycle when `resp_ready_i` is held high.
- Write accepted at edge N: shadow and `pending` reflect it from N+1. A read accepted at N+1 returns the new value.
- Commit evaluated at edge N: `pwmX_*_o` change at N+1. All five fields change in the same cycle and never separately.
- With mode 0 active, an apply takes effect the cycle after the APPLY write is accepted (write at N, commit at N+1, outputs at N+2).
- Reset mid-transaction drops any pending response and clears `pending`. Active outputs return to 0, which stops the generators.

## Test plan
- Reset, then read 0x04 -> rdata 0, err 0; all `pwm0_*`/`pwm1_*` outputs 0.
- Ch0 at mode 0: write PERIOD=10, THR1=4, MODE=1, then APPLY=1 -> `pwm0_period_o=10`, `pwm0_threshold1_o=4`, `pwm0_mode_o=1` exactly 2 cycles after the APPLY accept. Ch1 outputs stay 0.
- Ch0 active mode 1, period 10: write THR1=7, APPLY at arbitrary `bcnt` -> `pwm0_threshold1_o` stays 4 until the cycle after `bcnt==9`, then becomes 7. Read 0x14 returns 1 before the commit and 0 after.
- Byte strobe: write 0xAABBCCDD to 0x28 (ch1 THR1) with wstrb=0b0101 over existing 0 -> read 0x28 returns 0x00BB00DD.
- Errors: read 0x02 and write 0x18 -> err 1, rdata 0, no register change. Write MODE=0xFFFFFFFF -> read 0x00 returns 3.
- Backpressure: hold `resp_ready_i=0` with `req_valid_i=1` -> `req_ready_o=0`, response held stable for 5 cycles. Release -> next request accepted in the same cycle the response is consumed.
